// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS output encoder: three 8b/10b transition-minimised, DC-balanced
// channel encoders with control-token insertion during blanking.

module tmds_channel_enc (
    input  logic       clk,
    input  logic       aresetn,
    input  logic [7:0] d,
    input  logic       de,
    input  logic [1:0] c,
    output logic [9:0] tmds
);
    localparam logic [9:0] TOKEN_00 = 10'h354;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] v);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(v);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !v[0]);
        qm       = '0;
        qm[0]    = v[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ v[i]) : (qm[i-1] ^ v[i]);
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    function automatic logic [9:0] control_token(input logic [1:0] cc);
        case (cc)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    logic [8:0]        qm_p0;
    logic [8:0]        qm_p1;
    logic [3:0]        n1q_p1;
    logic              vld_p1;
    logic [1:0]        c_p1;
    logic [9:0]        tmds_p2;
    logic signed [5:0] cnt_p2;

    assign qm_p0 = transition_min(d);

    // Stage 1: transition-minimised word and its ones count
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            qm_p1  <= '0;
            n1q_p1 <= '0;
            vld_p1 <= 1'b0;
            c_p1   <= 2'b00;
        end else begin
            qm_p1  <= qm_p0;
            n1q_p1 <= popcount8(qm_p0[7:0]);
            vld_p1 <= de;
            c_p1   <= c;
        end
    end

    logic signed [5:0] n1q_s;
    logic signed [5:0] n0q_s;
    logic signed [5:0] bal;
    logic signed [5:0] cnt_nxt;
    logic [9:0]        tmds_nxt;

    assign n1q_s = signed'({2'b00, n1q_p1});
    assign n0q_s = 6'sd8 - n1q_s;
    assign bal   = n1q_s - n0q_s;

    always_comb begin
        tmds_nxt = control_token(c_p1);
        cnt_nxt  = '0;
        if (vld_p1) begin
            if ((cnt_p2 == 6'sd0) || (n1q_p1 == 4'd4)) begin
                tmds_nxt = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
                cnt_nxt  = qm_p1[8] ? (cnt_p2 + bal) : (cnt_p2 - bal);
            end else if (((cnt_p2 > 6'sd0) && (n1q_p1 > 4'd4)) ||
                         ((cnt_p2 < 6'sd0) && (n1q_p1 < 4'd4))) begin
                tmds_nxt = {1'b1, qm_p1[8], ~qm_p1[7:0]};
                cnt_nxt  = cnt_p2 + (qm_p1[8] ? 6'sd2 : 6'sd0) - bal;
            end else begin
                tmds_nxt = {1'b0, qm_p1[8], qm_p1[7:0]};
                cnt_nxt  = cnt_p2 - (qm_p1[8] ? 6'sd0 : 6'sd2) + bal;
            end
        end
    end

    // Stage 2: disparity-balanced character or control token
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tmds_p2 <= TOKEN_00;
            cnt_p2  <= '0;
        end else begin
            tmds_p2 <= tmds_nxt;
            cnt_p2  <= cnt_nxt;
        end
    end

    assign tmds = tmds_p2;
endmodule

module dvi_tmds_encoder #(
    parameter int RED_LSB   = 0,
    parameter int GREEN_LSB = 8,
    parameter int BLUE_LSB  = 16
) (
    input  logic        dvi_clk,
    input  logic        aresetn,
    input  logic [31:0] dvi_rgb,
    input  logic        dvi_hsync,
    input  logic        dvi_vsync,
    input  logic        dvi_active_video,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic        tmds_de
);
    logic vld_p1;
    logic vld_p2;
    logic unused_rgb;

    // The top byte of dvi_rgb carries nothing for the link.
    assign unused_rgb = ^dvi_rgb;

    tmds_channel_enc u_ch0 (
        .clk     (dvi_clk),
        .aresetn (aresetn),
        .d       (dvi_rgb[BLUE_LSB +: 8]),
        .de      (dvi_active_video),
        .c       ({dvi_vsync, dvi_hsync}),
        .tmds    (tmds_ch0)
    );

    tmds_channel_enc u_ch1 (
        .clk     (dvi_clk),
        .aresetn (aresetn),
        .d       (dvi_rgb[GREEN_LSB +: 8]),
        .de      (dvi_active_video),
        .c       (2'b00),
        .tmds    (tmds_ch1)
    );

    tmds_channel_enc u_ch2 (
        .clk     (dvi_clk),
        .aresetn (aresetn),
        .d       (dvi_rgb[RED_LSB +: 8]),
        .de      (dvi_active_video),
        .c       (2'b00),
        .tmds    (tmds_ch2)
    );

    // DE follows the same two-register path as the channel characters
    always_ff @(posedge dvi_clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= dvi_active_video;
            vld_p2 <= vld_p1;
        end
    end

    assign tmds_de = vld_p2;
endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: vector table, scoreboard with a
// behavioural reference encoder, running-disparity bound and reset sequences.

module tb_dvi_tmds_encoder;
    logic        dvi_clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] dvi_rgb = '0;
    logic        dvi_hsync = 1'b0;
    logic        dvi_vsync = 1'b0;
    logic        dvi_active_video = 1'b0;
    logic [9:0]  tmds_ch0;
    logic [9:0]  tmds_ch1;
    logic [9:0]  tmds_ch2;
    logic        tmds_de;

    dvi_tmds_encoder dut (
        .dvi_clk          (dvi_clk),
        .aresetn          (aresetn),
        .dvi_rgb          (dvi_rgb),
        .dvi_hsync        (dvi_hsync),
        .dvi_vsync        (dvi_vsync),
        .dvi_active_video (dvi_active_video),
        .tmds_ch0         (tmds_ch0),
        .tmds_ch1         (tmds_ch1),
        .tmds_ch2         (tmds_ch2),
        .tmds_de          (tmds_de)
    );

    always #5 dvi_clk = ~dvi_clk;

    typedef struct packed {
        logic [9:0] c0;
        logic [9:0] c1;
        logic [9:0] c2;
        logic       de;
    } exp_t;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [31:0] rgb;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   tests = 0;
    int   fails = 0;
    int   mcnt[3];
    int   disp[3];

    function automatic exp_t mk(input logic [9:0] a, input logic [9:0] b,
                                input logic [9:0] c, input logic d);
        exp_t e;
        e.c0 = a; e.c1 = b; e.c2 = c; e.de = d;
        return e;
    endfunction

    function automatic vec_t mkv(input logic de, input logic hs, input logic vs,
                                 input logic [31:0] rgb, input exp_t e);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs; v.rgb = rgb; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder; prefix parity form of the q_m recurrence.
    task automatic model_enc(input int ch, input logic [7:0] d, input logic de,
                             input logic [1:0] c, output logic [9:0] o);
        int         n1d, n1q, n0q, q8i;
        logic       use_xnor, p, q8;
        logic [7:0] qm;
        o = 10'h354;
        if (!de) begin
            case (c)
                2'b00:   o = 10'h354;
                2'b01:   o = 10'h0AB;
                2'b10:   o = 10'h154;
                default: o = 10'h2AB;
            endcase
            mcnt[ch] = 0;
        end else begin
            n1d      = $countones(d);
            use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            p = 1'b0;
            for (int i = 0; i < 8; i++) begin
                p     = p ^ d[i];
                qm[i] = p ^ (use_xnor && (i % 2 == 1));
            end
            q8  = ~use_xnor;
            q8i = q8 ? 1 : 0;
            n1q = $countones(qm);
            n0q = 8 - n1q;
            if (mcnt[ch] == 0 || n1q == 4) begin
                o = {~q8, q8, q8 ? qm : ~qm};
                mcnt[ch] += q8 ? (n1q - n0q) : (n0q - n1q);
            end else if ((mcnt[ch] > 0 && n1q > 4) || (mcnt[ch] < 0 && n1q < 4)) begin
                o = {1'b1, q8, ~qm};
                mcnt[ch] += 2 * q8i + n0q - n1q;
            end else begin
                o = {1'b0, q8, qm};
                mcnt[ch] += -2 * (1 - q8i) + n1q - n0q;
            end
        end
    endtask

    task automatic bal_check(input int ch, input logic [9:0] w);
        if (!tmds_de) begin
            disp[ch] = 0;
        end else begin
            disp[ch] += 2 * $countones(w) - 10;
            tests++;
            if (disp[ch] > 10 || disp[ch] < -10) begin
                fails++;
                $display("FAIL balance ch%0d: disparity %0d exceeds +-10 at %0t", ch, disp[ch], $time);
            end
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [31:0] rgb, input logic use_tbl, input exp_t te);
        logic [9:0] o0, o1, o2;
        exp_t       want;
        dvi_active_video = de;
        dvi_hsync        = hs;
        dvi_vsync        = vs;
        dvi_rgb          = rgb;
        model_enc(0, rgb[23:16], de, {vs, hs}, o0);
        model_enc(1, rgb[15:8],  de, 2'b00,    o1);
        model_enc(2, rgb[7:0],   de, 2'b00,    o2);
        sb.push_back(use_tbl ? te : mk(o0, o1, o2, de));
        @(posedge dvi_clk);
        @(negedge dvi_clk);
        want = sb.pop_front();
        check("ch0", tmds_ch0, want.c0);
        check("ch1", tmds_ch1, want.c1);
        check("ch2", tmds_ch2, want.c2);
        check("de",  {9'b0, tmds_de}, {9'b0, want.de});
        bal_check(0, tmds_ch0);
        bal_check(1, tmds_ch1);
        bal_check(2, tmds_ch2);
    endtask

    task automatic release_reset();
        sb.delete();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        sb.push_back(mk(10'h354, 10'h354, 10'h354, 1'b0));
        aresetn = 1'b1;
    endtask

    initial begin
        int   gap, run;
        exp_t none;
        none = mk(10'h0, 10'h0, 10'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin mcnt[i] = 0; disp[i] = 0; end

        tbl[0]  = mkv(0, 1, 0, 32'h0,        mk(10'h0AB, 10'h354, 10'h354, 0));
        tbl[1]  = mkv(0, 0, 0, 32'h0,        mk(10'h354, 10'h354, 10'h354, 0));
        tbl[2]  = mkv(0, 1, 0, 32'h0,        mk(10'h0AB, 10'h354, 10'h354, 0));
        tbl[3]  = mkv(0, 0, 1, 32'h0,        mk(10'h154, 10'h354, 10'h354, 0));
        tbl[4]  = mkv(0, 1, 1, 32'h0,        mk(10'h2AB, 10'h354, 10'h354, 0));
        tbl[5]  = mkv(1, 0, 0, 32'h0,        mk(10'h100, 10'h100, 10'h100, 1));
        tbl[6]  = mkv(1, 0, 0, 32'h0,        mk(10'h3FF, 10'h3FF, 10'h3FF, 1));
        tbl[7]  = mkv(1, 0, 0, 32'h0,        mk(10'h100, 10'h100, 10'h100, 1));
        tbl[8]  = mkv(0, 0, 0, 32'h0,        mk(10'h354, 10'h354, 10'h354, 0));
        tbl[9]  = mkv(1, 1, 1, 32'h0000FF00, mk(10'h100, 10'h200, 10'h100, 1));
        tbl[10] = mkv(0, 0, 0, 32'h0,        mk(10'h354, 10'h354, 10'h354, 0));
        tbl[11] = mkv(1, 0, 0, 32'h0,        mk(10'h100, 10'h100, 10'h100, 1));
        tbl[12] = mkv(1, 0, 0, 32'h00000001, mk(10'h3FF, 10'h3FF, 10'h1FF, 1));
        tbl[13] = mkv(1, 0, 0, 32'h00000001, mk(10'h100, 10'h100, 10'h1FF, 1));
        tbl[14] = mkv(1, 0, 0, 32'h00000001, mk(10'h3FF, 10'h3FF, 10'h300, 1));
        tbl[15] = mkv(0, 0, 0, 32'h0,        mk(10'h354, 10'h354, 10'h354, 0));

        // Reset held with arbitrary inputs
        aresetn          = 1'b0;
        dvi_active_video = 1'b1;
        dvi_rgb          = 32'hDEADBEEF;
        dvi_hsync        = 1'b1;
        dvi_vsync        = 1'b1;
        repeat (3) @(negedge dvi_clk);
        check("rst_ch0", tmds_ch0, 10'h354);
        check("rst_ch1", tmds_ch1, 10'h354);
        check("rst_ch2", tmds_ch2, 10'h354);
        check("rst_de",  {9'b0, tmds_de}, 10'h0);

        dvi_active_video = 1'b0;
        dvi_hsync        = 1'b1;
        dvi_vsync        = 1'b0;
        release_reset();

        for (int i = 0; i < 16; i++)
            step(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].rgb, 1'b1, tbl[i].e);

        // Random active runs separated by random blanking gaps
        for (int r = 0; r < 60; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0, none);
            run = $urandom_range(1, 40);
            for (int k = 0; k < run; k++)
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0, none);
        end

        // DE toggling every cycle
        for (int k = 0; k < 24; k++)
            step(1'(k % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0, none);

        // Reset pulse in the middle of active video
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b0, 1'b0, $urandom, 1'b0, none);
        aresetn = 1'b0;
        #1;
        check("midrst_ch0", tmds_ch0, 10'h354);
        check("midrst_ch1", tmds_ch1, 10'h354);
        check("midrst_ch2", tmds_ch2, 10'h354);
        check("midrst_de",  {9'b0, tmds_de}, 10'h0);
        @(posedge dvi_clk);
        @(negedge dvi_clk);
        check("midrst_hold_ch0", tmds_ch0, 10'h354);
        dvi_active_video = 1'b1;
        dvi_rgb          = 32'h0;
        release_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mk(10'h100, 10'h100, 10'h100, 1'b1));
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mk(10'h3FF, 10'h3FF, 10'h3FF, 1'b1));
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mk(10'h354, 10'h354, 10'h354, 1'b0));
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, none);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
